// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Single-clock FIFO with a parameterised width and depth. It offers a standard
// read mode with one cycle of latency, or a first-word-fall-through read mode.
// It also provides a fill level, programmable almost-full and almost-empty
// flags, a synchronous flush, and sticky overflow and underflow flags.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-high reset
//   flush        synchronous clear of pointers (contents become unreachable)
//   data_in      write data
//   wr_en        write request
//   rd_en        read request (standard) / pop of the head word (FWFT)
//   clr_err      synchronous clear of overflow/underflow
//   data_out     read data
//   empty        no readable entry
//   full         DEPTH entries stored
//   almost_empty count <= AE_LEVEL
//   almost_full  count >= AF_LEVEL
//   count        fill level 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_THR    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THR    = PTR_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  // The extra pointer MSB distinguishes full from empty when the addresses match.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  fill;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              unf_set;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // Status comes only from the registered pointers, so request inputs never
  // reach an output combinationally.
  assign fill         = wr_ptr - rd_ptr;
  assign count        = fill;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (fill == DEPTH_LVL);
  assign almost_full  = (fill >= AF_THR);
  assign almost_empty = (fill <= AE_THR);

  // Gating uses the pre-edge full/empty. As a result, a read from a full FIFO
  // frees a slot only for the next cycle, and a simultaneous write is dropped.
  // A flush suppresses both requests and the error detection in that cycle.
  assign wr_acc  = wr_en && !full  && !flush;
  assign rd_acc  = rd_en && !empty && !flush;
  assign ovf_set = wr_en && full   && !flush;
  assign unf_set = rd_en && empty  && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
      // A new error event takes priority over a clear in the same cycle.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown as soon as it is stored. While the FIFO is
      // empty the output is forced to zero, which also gives the reset value.
      assign data_out = empty ? '0 : mem[rd_addr];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // The output register loads only on an accepted read. It holds its
      // value through idle cycles and through a flush.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_addr];
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo. It drives a standard-mode instance and an
// FWFT instance (both DEPTH=16, DATA_W=8) from the same stimulus. Both are
// compared against a queue-based reference model after every clock edge.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = DP - 4;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic          clr_err;

  logic [DW-1:0] dout0, dout1;
  logic          e0, f0, ae0, af0, ov0, un0;
  logic          e1, f1, ae1, af1, ov1, un1;
  logic [4:0]    cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ov;
  logic          exp_un;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(dout0), .empty(e0),
    .full(f0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .overflow(ov0), .underflow(un0)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(dout1), .empty(e1),
    .full(f1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
    .overflow(ov1), .underflow(un1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ov   = 1'b0;
    exp_un   = 1'b0;
  endtask

  // Applies one clock edge to the model using the pre-edge queue state.
  task automatic model_edge(input logic w, input logic r, input logic fl,
                            input logic ce, input logic [DW-1:0] d);
    logic sov, sun, em, fu;
    sov = 1'b0;
    sun = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      em  = (q.size() == 0);
      fu  = (q.size() == DP);
      sov = w && fu;
      sun = r && em;
      if (r && !em) exp_dout = q.pop_front();
      if (w && !fu) q.push_back(d);
    end
    if (sov)     exp_ov = 1'b1;
    else if (ce) exp_ov = 1'b0;
    if (sun)     exp_un = 1'b1;
    else if (ce) exp_un = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_count",  32'(cnt0), 32'(n));
    chk("std_empty",  32'(e0),   32'(n == 0));
    chk("std_full",   32'(f0),   32'(n == DP));
    chk("std_aempty", 32'(ae0),  32'(n <= AE));
    chk("std_afull",  32'(af0),  32'(n >= AF));
    chk("std_ovf",    32'(ov0),  32'(exp_ov));
    chk("std_unf",    32'(un0),  32'(exp_un));
    chk("std_data",   32'(dout0), 32'(exp_dout));
    chk("fwft_count", 32'(cnt1), 32'(n));
    chk("fwft_empty", 32'(e1),   32'(n == 0));
    chk("fwft_full",  32'(f1),   32'(n == DP));
    chk("fwft_aempty",32'(ae1),  32'(n <= AE));
    chk("fwft_afull", 32'(af1),  32'(n >= AF));
    chk("fwft_ovf",   32'(ov1),  32'(exp_ov));
    chk("fwft_unf",   32'(un1),  32'(exp_un));
    if (n != 0) chk("fwft_data", 32'(dout1), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic fl,
                      input logic ce, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    flush   = fl;
    clr_err = ce;
    data_in = d;
    @(posedge clk);
    model_edge(w, r, fl, ce, d);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    check_all();
  endtask

  task automatic drain();
    while (q.size() != 0) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic w, r, fl, ce;

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    clr_err = 1'b0; data_in = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // Fill to full, attempt an extra write, then read everything back.
    for (int i = 1; i <= DP; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < DP; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Hold level 8 with concurrent traffic across the address wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h28 + i));
    drain();

    // Full with write+read, then empty with write+read, then clear the errors.
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    drain();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    drain();

    // FWFT presentation: write to empty, idle, write, then pop.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5B);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drain();

    // Flush at level 10 with a concurrent write, leaving an error flag set.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h90 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hCC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset asserted between edges at level 6.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hB0 + i));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hD0 + i));
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 2);
      ce = ($urandom_range(0, 99) < 4);
      d  = 8'($urandom);
      step(w, r, fl, ce, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO: the next generation of the team's 8-bit byte buffer, generalised in width and depth. Adds a selectable first-word-fall-through (FWFT) read mode, a fill-level output, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Sits between producer and consumer stages in the same clock domain, e.g. ingress byte/word staging ahead of packet parsers.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 1024, number of entries; power of two, >=4
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = head word presented on data_out while !empty
AF_LEVEL, DEPTH-4, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents and pointers
data_in  in  DATA_W  write data
wr_en  in  1  write request
rd_en  in  1  read request (standard) / pop-acknowledge (FWFT)
clr_err  in  1  synchronous clear of sticky error flags
data_out  out  DATA_W  read data
empty  out  1  no readable entry
full  out  1  DEPTH entries stored
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
count  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_LEVEL=0, disallowed), overflow=underflow=0. Memory contents not reset.
- Pointers $clog2(DEPTH)+1 bits; address = low $clog2(DEPTH) bits; natural wrap modulo 2*DEPTH. empty = (wr_ptr==rd_ptr); full = (wr_ptr-rd_ptr == DEPTH); count = wr_ptr-rd_ptr.
- All status outputs derived from registered state only; no combinational path from wr_en/rd_en/data_in to any output.
- Accepted write: wr_en && !full -> mem[wr_addr]<=data_in, wr_ptr+1.
- Accepted read: rd_en && !empty -> rd_ptr+1.
- Full gating uses pre-edge state: wr_en with rd_en while full -> read accepted, write dropped, overflow set. rd_en with wr_en while empty -> write accepted, read ignored, underflow set.
- Simultaneous accepted read+write: count unchanged, both pointers advance.
- Standard mode (FWFT=0): on accepted read, data_out <= mem[rd_addr] at the same edge (1-cycle latency); data_out holds value otherwise, including after flush.
- FWFT mode: data_out = mem[rd_addr] whenever !empty; word written into empty FIFO visible on data_out the cycle after its write edge (same cycle empty falls). rd_en pops head; next entry appears the following cycle. data_out undefined/don't-care while empty.
- flush=1: pointers to 0 next edge, count=0, empty=1; any wr_en/rd_en that cycle ignored; error flags unaffected; data_out unchanged in standard mode.
- overflow/underflow: set on offending attempt, held until clr_err or rst. Set and clr_err same cycle -> set wins.
- rst asserted mid-operation: immediate (async) return to reset values; in-flight writes lost.

Test Plan:
- DEPTH=16, DATA_W=8, FWFT=0: write 0x01..0x10 -> full=1, count=16, almost_full=1 from count 12; 17th write 0xAA dropped, overflow=1; read 16 -> data_out 0x01..0x10, each one cycle after rd_en, empty=1 after last.
- Fill to 8 then assert wr_en+rd_en 20 cycles with incrementing data -> count stays 8, output order strictly sequential across pointer wrap (addr 15->0).
- Full FIFO, wr_en+rd_en same cycle -> count 15, overflow=1, dropped word never read; empty FIFO, wr_en+rd_en -> count 1, underflow=1; clr_err -> both flags 0.
- FWFT=1: write 0x5A to empty -> next cycle empty=0, data_out=0x5A with no rd_en; write 0x5B, pulse rd_en -> data_out=0x5B next cycle.
- Count 10, flush=1 with wr_en=1 -> next cycle count=0, empty=1, almost_empty=1, written word discarded; errors unchanged.
- Count 6, assert rst asynchronously between edges -> outputs reach reset values before next rising edge; operation resumes normally after release.
